// File: rtl/trace_pkg.sv
// trace_pkg: shared frame sizes, serializer states and the 224-bit trace record layout
package trace_pkg;
  localparam int FRAME_BYTES   = 29;
  localparam int PAYLOAD_BYTES = 28;
  localparam int REC_W         = 224;
  typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;
  typedef struct packed {
    logic [63:0] counter;
    logic [31:0] instruction;
    logic [63:0] alu_out;
    logic [63:0] mem_data;
  } rec_t;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: REC_W x DEPTH sync FIFO; push/pop/din in, dout (head), full/empty/level out; caller guards push/pop
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [REC_W-1:0]         din,
  output logic [REC_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [REC_W-1:0] mem_q [DEPTH];
  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = (push && !pop) ? cnt_q + 1'b1 : (!push && pop) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clock)
    if (push) mem_q[wr_q] <= din;
  assign dout  = mem_q[rd_q];
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign level = cnt_q;
endmodule

// File: rtl/cpu_trace_streamer.sv
// cpu_trace_streamer: captures CPU bus records (counter/instruction/alu_out/mem_data) into a FIFO and streams 29-byte frames on out_data/out_valid/out_ready; overflow, level status
module cpu_trace_streamer
  import trace_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [7:0]  HDR_BYTE = 8'hA5
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear_overflow,
  input  logic [63:0]            counter,
  input  logic [31:0]            instruction,
  input  logic [63:0]            alu_out,
  input  logic [63:0]            mem_data,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);
  rec_t             din;
  logic [REC_W-1:0] head;
  logic             full, empty, push, pop, hs, last;
  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [REC_W-1:0] sr_q, sr_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d, overflow_q, overflow_d;
  assign din = {counter, instruction, alu_out, mem_data};
  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .reset_n(reset_n),
    .push   (push),
    .pop    (pop),
    .din    (din),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );
  // The shift register always holds the next byte to send in its top 8 bits.
  always_comb begin
    hs          = out_valid_q && out_ready;
    last        = state_q == PAY && idx_q == 5'(PAYLOAD_BYTES-1) && hs;
    pop         = !empty && (state_q == IDLE || last);
    push        = enable && (!full || pop);
    overflow_d  = (enable && full && !pop) ? 1'b1 : clear_overflow ? 1'b0 : overflow_q;
    state_d     = state_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (pop) begin
      state_d     = HDR;
      sr_d        = head;
      out_data_d  = HDR_BYTE;
      out_valid_d = 1'b1;
    end else if (last) begin
      state_d     = IDLE;
      out_data_d  = 8'h00;
      out_valid_d = 1'b0;
    end else if (hs) begin
      state_d    = PAY;
      idx_d      = state_q == HDR ? 5'd0 : idx_q + 1'b1;
      out_data_d = sr_q[REC_W-1 -: 8];
      sr_d       = sr_q << 8;
    end
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      sr_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_cpu_trace_streamer.sv
// tb_cpu_trace_streamer: vector table, corner sequences and random traffic against a queue-based frame model
module tb_cpu_trace_streamer;
  localparam int DEPTH = 8;
  logic        clock = 0, reset_n = 0, enable = 0, clear_overflow = 0, out_ready = 0;
  logic [63:0] counter = 0, alu_out = 0, mem_data = 0;
  logic [31:0] instruction = 0;
  logic [7:0]  out_data;
  logic        out_valid, overflow;
  logic [3:0]  level;
  cpu_trace_streamer #(.DEPTH(DEPTH), .HDR_BYTE(8'hA5)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear_overflow(clear_overflow),
    .counter(counter), .instruction(instruction), .alu_out(alu_out), .mem_data(mem_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .level(level)
  );
  always #5 clock = ~clock;
  int n_checks = 0, n_fail = 0;
  logic [223:0] m_fifo[$];
  logic [7:0]   m_cur[$];
  logic [7:0]   got[$];
  logic         m_ovf = 0;
  logic [7:0]   last_data = 0;
  typedef struct {
    logic [63:0]  cnt;
    logic [31:0]  ins;
    logic [63:0]  alu;
    logic [63:0]  mem;
    int           stall_at;
    int           stall_len;
    logic [231:0] exp;
  } vec_t;
  vec_t vt[4];
  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void load_frame(logic [223:0] r);
    m_cur.delete();
    m_cur.push_back(8'hA5);
    for (int i = 0; i < 28; i++) m_cur.push_back(r[223-8*i -: 8]);
  endfunction
  function automatic void model_reset();
    m_fifo.delete();
    m_cur.delete();
    got.delete();
    m_ovf = 0;
  endfunction
  function automatic logic [63:0] counter_of(int f);
    logic [63:0] r = 0;
    for (int k = 1; k <= 8; k++) r = {r[55:0], got[f*29+k]};
    return r;
  endfunction
  // One clock edge: the frame being sent is a byte queue; when it empties the
  // next buffered record (if any) becomes the next frame on that same edge.
  task automatic step();
    bit hs, pop, full, push, drop;
    @(posedge clock);
    hs = m_cur.size() > 0 && out_ready;
    if (hs) begin
      got.push_back(last_data);
      void'(m_cur.pop_front());
    end
    pop  = m_fifo.size() > 0 && m_cur.size() == 0;
    full = m_fifo.size() == DEPTH;
    push = enable && (!full || pop);
    drop = enable && full && !pop;
    if (pop) load_frame(m_fifo.pop_front());
    if (push) m_fifo.push_back({counter, instruction, alu_out, mem_data});
    if (drop) m_ovf = 1;
    else if (clear_overflow) m_ovf = 0;
    #1;
    chk("out_valid", 256'(out_valid), 256'(m_cur.size() > 0));
    if (m_cur.size() > 0) chk("out_data", 256'(out_data), 256'(m_cur[0]));
    chk("level", 256'(level), 256'(m_fifo.size()));
    chk("overflow", 256'(overflow), 256'(m_ovf));
    last_data = out_data;
  endtask
  task automatic drain(int budget);
    int n = 0;
    while ((m_cur.size() > 0 || m_fifo.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 256'(m_cur.size() + m_fifo.size()), 256'(0));
  endtask
  task automatic capture(logic [63:0] c);
    counter     = c;
    instruction = $urandom;
    alu_out     = {$urandom, $urandom};
    mem_data    = {$urandom, $urandom};
    enable      = 1;
    step();
    enable      = 0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0] = '{64'h4, 32'hF8400001, 64'd10, 64'd55, -1, 0,
              232'hA5_0000000000000004_F8400001_000000000000000A_0000000000000037};
    vt[1] = '{64'h4, 32'hF8400001, 64'd10, 64'd55, 10, 5,
              232'hA5_0000000000000004_F8400001_000000000000000A_0000000000000037};
    vt[2] = '{64'h0123456789ABCDEF, 32'hDEADBEEF, 64'hFEDCBA9876543210, 64'h1122334455667788, 0, 3,
              232'hA5_0123456789ABCDEF_DEADBEEF_FEDCBA9876543210_1122334455667788};
    vt[3] = '{'1, '1, '1, '1, 28, 2,
              232'hA5_FFFFFFFFFFFFFFFF_FFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF};
    // reset held with live inputs
    enable = 1; out_ready = 1;
    repeat (4) begin
      @(negedge clock);
      counter = {$urandom, $urandom};
      clear_overflow = ~clear_overflow;
      chk("rst_valid", 256'(out_valid), 256'(0));
      chk("rst_level", 256'(level), 256'(0));
      chk("rst_overflow", 256'(overflow), 256'(0));
    end
    enable = 0; clear_overflow = 0;
    reset_n = 1;
    model_reset();
    // table-driven single-record frames with optional backpressure
    foreach (vt[t]) begin
      int stalled = 0, n = 0;
      logic [231:0] fr = 0;
      counter = vt[t].cnt; instruction = vt[t].ins; alu_out = vt[t].alu; mem_data = vt[t].mem;
      out_ready = 1; got.delete();
      enable = 1;
      step();
      enable = 0;
      step();
      chk("hdr_after_capture", 256'({out_valid, out_data}), 256'({1'b1, 8'hA5}));
      while ((m_cur.size() > 0 || m_fifo.size() > 0) && n < 200) begin
        out_ready = !(m_cur.size() > 0 && got.size() == vt[t].stall_at && stalled < vt[t].stall_len);
        if (!out_ready) stalled++;
        step();
        n++;
      end
      out_ready = 1;
      chk("frame_len", 256'(got.size()), 256'(29));
      foreach (got[k]) fr = {fr[223:0], got[k]};
      chk("frame_bytes", 256'(fr), 256'(vt[t].exp));
      chk("idle_after_frame", 256'(out_valid), 256'(0));
    end
    // overflow: serializer takes record 0, FIFO keeps 1..8, 9..11 dropped
    out_ready = 0;
    for (int i = 0; i < 12; i++) capture(64'(i));
    chk("ovf_level", 256'(level), 256'(8));
    chk("ovf_flag", 256'(overflow), 256'(1));
    out_ready = 1; got.delete();
    drain(400);
    chk("ovf_frames", 256'(got.size()), 256'(9*29));
    for (int f = 0; f < 9; f++) chk("ovf_order", 256'(counter_of(f)), 256'(f));
    clear_overflow = 1;
    step();
    clear_overflow = 0;
    chk("ovf_cleared", 256'(overflow), 256'(0));
    // full FIFO, push on the same edge as the last-byte pop
    out_ready = 0;
    for (int i = 0; i < 9; i++) capture(64'(100 + i));
    chk("pp_full_level", 256'(level), 256'(8));
    out_ready = 1;
    begin
      int n = 0;
      while (m_cur.size() != 1 && n < 100) begin
        step();
        n++;
      end
      chk("pp_reach_last", 256'(m_cur.size()), 256'(1));
    end
    capture(64'd200);
    chk("pp_level", 256'(level), 256'(8));
    chk("pp_overflow", 256'(overflow), 256'(0));
    chk("pp_next_hdr", 256'({out_valid, out_data}), 256'({1'b1, 8'hA5}));
    drain(600);
    // asynchronous reset in the middle of a frame
    capture(64'h55);
    repeat (10) step();
    #3;
    reset_n = 0;
    #1;
    chk("midrst_valid", 256'(out_valid), 256'(0));
    chk("midrst_level", 256'(level), 256'(0));
    chk("midrst_data", 256'(out_data), 256'(0));
    model_reset();
    @(negedge clock);
    reset_n = 1;
    last_data = 0;
    capture(64'h77);
    step();
    chk("midrst_new_hdr", 256'({out_valid, out_data}), 256'({1'b1, 8'hA5}));
    drain(100);
    // continuous capture 0,4,..,36 while draining; the tenth record finds the FIFO full
    got.delete(); out_ready = 1;
    for (int i = 0; i < 10; i++) capture(64'(4*i));
    drain(600);
    chk("cont_overflow", 256'(overflow), 256'(1));
    chk("cont_bytes", 256'(got.size()), 256'(9*29));
    for (int f = 0; f < 9; f++) chk("cont_order", 256'(counter_of(f)), 256'(4*f));
    clear_overflow = 1;
    step();
    clear_overflow = 0;
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      enable = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      clear_overflow = $urandom_range(0, 19) == 0;
      counter = {$urandom, $urandom};
      instruction = $urandom;
      alu_out = {$urandom, $urandom};
      mem_data = {$urandom, $urandom};
      step();
    end
    enable = 0; clear_overflow = 0; out_ready = 1;
    drain(1000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
